// File: rtl/fx2_pkg.sv
// fx2_pkg: shared types and constants for the FX2 slave-FIFO controller.
package fx2_pkg;
  typedef enum logic [2:0] {IDLE, RD_OE, RD, WR_SEL, WR, WR_END} state_t;
  localparam logic [1:0] EP_OUT_DEF = 2'b00;
  localparam logic [1:0] EP_IN_DEF = 2'b10;
  localparam logic [3:0] HDR_MAGIC = 4'hA;
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fx2_slavefifo_mc_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick of the first request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (!found && req[i] && PW'(i) >= ptr) begin
        grant[i] = 1'b1;
        found = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found = 1'b1;
      end
  end
endmodule

// File: rtl/fx2_slavefifo_mc.sv
// fx2_slavefifo_mc: FX2 slave-FIFO controller; NCH round-robin upload channels into EP6, EP2 drained to dn stream.
// Define FX2_CHID_HDR_EN to prefix every IN packet with a magic/channel/sequence header word.
module fx2_slavefifo_mc
  import fx2_pkg::*;
#(
  parameter int DW = 16,
  parameter int NCH = 4,
  parameter int PKT_WORDS = 256,
  parameter int RD_MAX = 64,
  parameter logic [1:0] EP_OUT = EP_OUT_DEF,
  parameter logic [1:0] EP_IN = EP_IN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DW-1:0]     cy_data,
  output logic [1:0]        cy_addr,
  output logic              cy_slrd_n,
  output logic              cy_slwr_n,
  output logic              cy_sloe_n,
  output logic              cy_pkend_n,
  input  logic              cy_flaga,
  input  logic              cy_flagb,
  output logic              cy_ifclk,
  input  logic [NCH-1:0]    up_req,
  output logic [NCH-1:0]    up_grant,
  input  logic [NCH*DW-1:0] up_dat,
  output logic [NCH-1:0]    up_fin,
  output logic              dn_val,
  output logic [DW-1:0]     dn_dat
);
  localparam int PW = clog2(NCH);
  localparam int WW = clog2(PKT_WORDS);
  localparam int RW = clog2(RD_MAX + 1);
  localparam logic [WW-1:0] WR_LAST = WW'(PKT_WORDS - 1);
  localparam logic [RW-1:0] RD_LIM = RW'(RD_MAX);
  localparam logic [PW-1:0] CH_LAST = PW'(NCH - 1);

  state_t state, state_nx;
  logic [NCH-1:0] req_q, arb_grant;
  logic [PW-1:0] ptr, ch, arb_ch;
  logic [WW-1:0] wr_cnt;
  logic [RW-1:0] rd_cnt;
  logic rd_fire, wr_fire, hdr, drive;
  logic [DW-1:0] ch_dat, wr_word;

  rr_arbiter #(.N(NCH), .PW(PW)) u_arb (.req(req_q), .ptr(ptr), .grant(arb_grant));

  always_comb begin
    arb_ch = '0;
    ch_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_grant[i]) arb_ch = PW'(i);
      if (ch == PW'(i)) ch_dat = up_dat[i*DW +: DW];
    end
  end

`ifdef FX2_CHID_HDR_EN
  logic [7:0] seq [NCH];
  assign hdr = wr_cnt == '0;
  assign wr_word = hdr ? {HDR_MAGIC, 3'(ch), (DW-7)'(seq[ch])} : ch_dat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NCH; i++) seq[i] <= '0;
    else if (state == WR_END) seq[ch] <= seq[ch] + 8'd1;
`else
  assign hdr = 1'b0;
  assign wr_word = ch_dat;
`endif

  // Bus is only driven in WR, so WR_SEL/WR_END/IDLE give the hi-Z turnaround cycles.
  assign cy_data = drive ? wr_word : 'z;
  assign cy_ifclk = ~clk;
  assign cy_pkend_n = 1'b1;

  always_comb begin
    state_nx = state;
    cy_addr = EP_OUT;
    cy_sloe_n = 1'b1;
    cy_slrd_n = 1'b1;
    cy_slwr_n = 1'b1;
    drive = 1'b0;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    up_grant = '0;
    up_fin = '0;
    case (state)
      IDLE: state_nx = cy_flaga ? RD_OE : (|req_q && cy_flagb) ? WR_SEL : IDLE;
      RD_OE: begin
        cy_sloe_n = 1'b0;
        state_nx = RD;
      end
      RD: begin
        cy_sloe_n = 1'b0;
        rd_fire = cy_flaga && rd_cnt < RD_LIM;
        cy_slrd_n = !rd_fire;
        state_nx = rd_fire ? RD : IDLE;
      end
      WR_SEL: begin
        cy_addr = EP_IN;
        state_nx = |arb_grant ? WR : IDLE;
      end
      WR: begin
        cy_addr = EP_IN;
        drive = 1'b1;
        wr_fire = cy_flagb;
        cy_slwr_n = !wr_fire;
        up_grant[ch] = wr_fire && !hdr;
        state_nx = (wr_fire && wr_cnt == WR_LAST) ? WR_END : WR;
      end
      WR_END: begin
        cy_addr = EP_IN;
        up_fin[ch] = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // Requests are registered once so arbitration sees a stable snapshot.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_q <= '0;
      ptr <= '0;
      ch <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      dn_val <= 1'b0;
      dn_dat <= '0;
    end else begin
      req_q <= up_req;
      dn_val <= rd_fire;
      if (rd_fire) dn_dat <= cy_data;
      rd_cnt <= rd_fire ? rd_cnt + 1'b1 : '0;
      if (state == WR_SEL) ch <= arb_ch;
      if (wr_fire) wr_cnt <= (wr_cnt == WR_LAST) ? '0 : wr_cnt + 1'b1;
      if (state == WR_END) ptr <= (ch == CH_LAST) ? '0 : ch + 1'b1;
    end
endmodule

// File: tb/tb_fx2_slavefifo_mc.sv
// tb_fx2_slavefifo_mc: scoreboard bench with an FX2 FIFO model and counting upload sources.
module tb_fx2_slavefifo_mc;
  localparam int DW = 16, NCH = 4, PKT = 256;
  typedef struct { int ch; logic [DW-1:0] dat; logic hdr; } wr_t;

  logic clk = 0, rst_n = 1;
  wire [DW-1:0] cy_data;
  logic [1:0] cy_addr;
  logic cy_slrd_n, cy_slwr_n, cy_sloe_n, cy_pkend_n, cy_ifclk;
  logic cy_flaga = 0, cy_flagb = 1;
  logic [NCH-1:0] up_req = '0, up_grant, up_fin;
  logic [NCH*DW-1:0] up_dat;
  logic dn_val;
  logic [DW-1:0] dn_dat, fd = '0;
  int checks = 0, failures = 0, wr_seen = 0, dn_seen = 0;
  int src_cnt [NCH];
  int exp_cnt [NCH];
`ifdef FX2_CHID_HDR_EN
  int seq_m [NCH];
`endif
  logic [DW-1:0] out_q[$], rd_exp[$];
  int fin_exp[$];
  wr_t wr_exp[$];
  logic rd_strobe = 0, prev_slwr = 1;
  logic [NCH-1:0] g_s = '0;

  fx2_slavefifo_mc dut (
    .clk(clk), .rst_n(rst_n), .cy_data(cy_data), .cy_addr(cy_addr),
    .cy_slrd_n(cy_slrd_n), .cy_slwr_n(cy_slwr_n), .cy_sloe_n(cy_sloe_n),
    .cy_pkend_n(cy_pkend_n), .cy_flaga(cy_flaga), .cy_flagb(cy_flagb),
    .cy_ifclk(cy_ifclk), .up_req(up_req), .up_grant(up_grant), .up_dat(up_dat),
    .up_fin(up_fin), .dn_val(dn_val), .dn_dat(dn_dat)
  );

  always #5 clk = ~clk;
  assign cy_data = !cy_sloe_n ? fd : 'z;

  always_comb begin
    up_dat = '0;
    for (int i = 0; i < NCH; i++) up_dat[i*DW +: DW] = DW'((i << 12) | (src_cnt[i] & 'hFFF));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fx2_refresh();
    cy_flaga = out_q.size() != 0;
    fd = out_q.size() != 0 ? out_q[0] : '0;
  endtask

  task automatic load(input logic [DW-1:0] w);
    out_q.push_back(w);
    rd_exp.push_back(w);
    fx2_refresh();
  endtask

  task automatic push_pkt(input int c);
    int n = PKT;
`ifdef FX2_CHID_HDR_EN
    wr_exp.push_back('{c, {4'hA, 3'(c), 9'(seq_m[c])}, 1'b1});
    seq_m[c] = (seq_m[c] + 1) % 256;
    n--;
`endif
    for (int k = 0; k < n; k++) begin
      wr_exp.push_back('{c, DW'((c << 12) | (exp_cnt[c] & 'hFFF)), 1'b0});
      exp_cnt[c]++;
    end
    fin_exp.push_back(c);
  endtask

  task automatic wait_fin(input int c);
    int n = 0;
    while (!up_fin[c] && n < 700) begin tick(); n++; end
    if (!up_fin[c]) begin
      checks++; failures++;
      $display("FAIL fin_timeout ch=%0d actual=%b required=fin", c, up_fin);
    end
  endtask

  task automatic wait_words(input int base, input int k);
    int n = 0;
    while (wr_seen - base < k && n < 700) begin tick(); n++; end
    if (wr_seen - base < k) begin
      checks++; failures++;
      $display("FAIL words_timeout actual=%0d required=%0d", wr_seen - base, k);
    end
  endtask

  task automatic drain_reads();
    int n = 0;
    while (rd_exp.size() != 0 && n < 100) begin tick(); n++; end
    chk("rd_drain", rd_exp.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_slrd", cy_slrd_n, 1);
    chk("rst_slwr", cy_slwr_n, 1);
    chk("rst_sloe", cy_sloe_n, 1);
    chk("rst_pkend", cy_pkend_n, 1);
    chk("rst_addr", cy_addr, 2'b00);
    chk("rst_grant", up_grant, 0);
    chk("rst_fin", up_fin, 0);
    chk("rst_dn_val", dn_val, 0);
    chk("rst_dn_dat", dn_dat, 0);
    wr_exp.delete();
    fin_exp.delete();
    for (int i = 0; i < NCH; i++) begin
      src_cnt[i] = 0;
      exp_cnt[i] = 0;
`ifdef FX2_CHID_HDR_EN
      seq_m[i] = 0;
`endif
    end
    tick();
    tick();
    rst_n = 1;
  endtask

  // FX2 OUT FIFO model: pops the word consumed by each read strobe.
  initial forever begin
    @(negedge clk);
    rd_strobe = !cy_slrd_n && rst_n;
    @(posedge clk);
    #1;
    if (rd_strobe && out_q.size() != 0) void'(out_q.pop_front());
    fx2_refresh();
  end

  // Upload sources advance one word per granted cycle.
  initial forever begin
    @(negedge clk);
    g_s = rst_n ? up_grant : '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (g_s[i]) src_cnt[i]++;
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dn_val) begin
          dn_seen++;
          if (rd_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL dn_unexpected actual=%h required=none", dn_dat);
          end else chk("dn_dat", dn_dat, rd_exp.pop_front());
        end
        if (!cy_slwr_n) begin
          wr_seen++;
          chk("wr_flagb", cy_flagb, 1);
          if (wr_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL wr_unexpected actual=%h required=none", cy_data);
          end else begin
            e = wr_exp.pop_front();
            chk("wr_addr", cy_addr, 2'b10);
            chk("wr_dat", cy_data, e.dat);
            chk("wr_grant", up_grant, e.hdr ? 0 : (1 << e.ch));
          end
        end else chk("idle_grant", up_grant, 0);
        if (|up_fin) begin
          chk("pkend", cy_pkend_n, 1);
          if (fin_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL fin_unexpected actual=%b required=none", up_fin);
          end else chk("fin", up_fin, 1 << fin_exp.pop_front());
        end
        if (!cy_sloe_n) chk("turnaround", {cy_slwr_n, prev_slwr}, 2'b11);
        prev_slwr = cy_slwr_n;
      end else prev_slwr = 1;
    end
  end

  initial begin
    int n, base;
    #3;
    do_reset();
    tick();
    load(16'h4C4F); load(16'h5044); load(16'h0001);
    n = 0;
    while (!dn_val && n < 20) begin tick(); n++; end
    chk("rd_latency", n, 3);
    drain_reads();
    repeat (4) tick();
    chk("rd_count", dn_seen, 3);
    chk("flaga_empty", cy_flaga, 0);

    base = wr_seen;
    up_req = 4'b0001;
    push_pkt(0);
    n = 0;
    while (cy_slwr_n && n < 20) begin tick(); n++; end
    chk("wr_latency", n, 3);
    wait_fin(0);
    up_req = '0;
    chk("pkt_len0", wr_seen - base, PKT);

    base = wr_seen;
    up_req = 4'b0010;
    push_pkt(1);
    wait_words(base, 100);
    cy_flagb = 0;
    repeat (10) tick();
    chk("paused_words", wr_seen - base, 100);
    cy_flagb = 1;
    wait_fin(1);
    up_req = '0;
    chk("pkt_len1", wr_seen - base, PKT);

    base = wr_seen;
    up_req = 4'b0100;
    push_pkt(2);
    wait_words(base, 20);
    load(16'hBEEF); load(16'h1234);
    wait_fin(2);
    up_req = '0;
    chk("rd_deferred", rd_exp.size(), 2);
    chk("pkt_len2", wr_seen - base, PKT);
    drain_reads();

    do_reset();
    up_req = 4'b1111;
    push_pkt(0); push_pkt(1); push_pkt(2); push_pkt(3); push_pkt(0);
    wait_fin(0); wait_fin(1); wait_fin(2); wait_fin(3); wait_fin(0);
    up_req = '0;
    repeat (3) tick();
    chk("rr_fin_left", fin_exp.size(), 0);

    base = wr_seen;
    up_req = 4'b0010;
    push_pkt(1);
    wait_words(base, 50);
    do_reset();
    push_pkt(1);
    base = wr_seen;
    wait_fin(1);
    up_req = '0;
    chk("pkt_len_rst", wr_seen - base, PKT);

    repeat (5) tick();
    chk("wr_q_empty", wr_exp.size(), 0);
    chk("fin_q_empty", fin_exp.size(), 0);
    chk("rd_q_empty", rd_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fx2_slavefifo_mc.md
Name: fx2_slavefifo_mc

Overview:
- Next-generation FX2 slave-FIFO controller: one FX2 bus, NCH upload channels, one download stream.
- Arbitrates the NCH upload requesters round-robin into fixed-length EP6 IN packets.
- Drains EP2 OUT words into a dn_val/dn_dat stream.
- Sits between the ADC/DSP datapath and the CY7C68013 pins; cy_data width is parametrised.

Parameters:
- DW, 16, FX2 bus and channel word width (8 or 16).
- NCH, 4, number of upload channels (1..8).
- PKT_WORDS, 256, words per IN packet (2..1024).
- RD_MAX, 64, maximum OUT words read per visit before re-arbitration.
- EP_OUT, 2'b00, FIFOADR value for the OUT endpoint (EP2).
- EP_IN, 2'b10, FIFOADR value for the IN endpoint (EP6).

Ports:
- clk  in  1  system clock; FX2 IFCLK domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cy_data  inout  DW  FX2 FD bus.
- cy_addr  out  2  FIFOADR.
- cy_slrd_n  out  1  FX2 read strobe.
- cy_slwr_n  out  1  FX2 write strobe.
- cy_sloe_n  out  1  FX2 output enable.
- cy_pkend_n  out  1  FX2 packet-end strobe.
- cy_flaga  in  1  high = EP2 OUT not empty.
- cy_flagb  in  1  high = EP6 IN not full.
- cy_ifclk  out  1  ~clk, forwarded to the FX2.
- up_req  in  NCH  per-channel packet request; level-held.
- up_grant  out  NCH  one-hot; high in every cycle a word of that channel is consumed.
- up_dat  in  NCH*DW  per-channel data; channel i is at bits [i*DW +: DW]; prefetched (valid before grant).
- up_fin  out  NCH  one-cycle pulse after the channel's last packet word.
- dn_val  out  1  download word valid.
- dn_dat  out  DW  download word.

Behaviour:
- Reset (async): state IDLE; cy_slrd_n, cy_slwr_n, cy_sloe_n and cy_pkend_n all 1; cy_addr = EP_OUT; cy_data hi-Z; up_grant, up_fin and dn_val 0; dn_dat 0; round-robin pointer 0; word counters 0.
- FSM states: IDLE, RD_OE, RD, WR_SEL, WR, WR_END.
- IDLE: read has priority. cy_flaga=1 -> RD_OE. Otherwise, any up_req and cy_flagb=1 -> WR_SEL.
- RD_OE:
  - cy_addr=EP_OUT; cy_sloe_n=0 for 1 cycle; -> RD.
- RD:
  - While cy_flaga=1 and rd_cnt<RD_MAX: cy_slrd_n=0; dn_val=1 and dn_dat=cy_data, registered, 1 cycle after each strobe cycle.
  - On flaga=0 or rd_cnt=RD_MAX: strobes deassert, sloe_n returns 1 the next cycle, -> IDLE.
  - rd_cnt clears on exit.
- WR_SEL:
  - Grant the first requesting channel at or after the pointer, wrapping at NCH-1 -> 0.
  - cy_addr=EP_IN; cy_sloe_n=1; bus is driven from the next cycle; -> WR.
- WR:
  - Each cycle with cy_flagb=1: cy_slwr_n=0, cy_data=up_dat[ch], up_grant[ch]=1, wr_cnt+1.
  - cy_flagb=0 mid-packet: slwr_n=1 and grant=0; wr_cnt holds; resume when flagb returns.
  - At wr_cnt=PKT_WORDS-1 consumed -> WR_END.
- WR_END:
  - FX2 autocommits on full PKT_WORDS, so pkend is not pulsed.
  - up_fin[ch]=1 for 1 cycle; pointer=ch+1 (mod NCH); -> IDLE.
- Fairness: no channel is granted twice while another channel has had up_req high across that interval.
- up_req dropped mid-packet is ignored; the packet always completes.
- Turnaround: at least 1 idle cycle with cy_data hi-Z between sloe_n=0 and the first write-drive cycle, and vice versa.
- Latency: first dn_val 3 cycles after cy_flaga rises in IDLE.
- Latency: first slwr_n=0 3 cycles after up_req rises in IDLE, provided flagb=1 and no read is pending.
- rst_n asserted mid-operation: all outputs return to reset values immediately; the partial IN packet is abandoned and no pkend is issued.

Optional Feature:
- Macro: FX2_CHID_HDR_EN.
- When defined, each IN packet starts with one header word: bits[DW-1:DW-4]=4'hA, bits[DW-5:DW-7]=channel id, low bits=per-channel 8-bit packet sequence number (wraps 255->0).
- The header counts within PKT_WORDS, so the payload is PKT_WORDS-1 words.
- up_grant stays low during the header word.
- Sequence counters reset to 0.
- When undefined, no header is sent and there are no sequence counters; payload is PKT_WORDS words.

Decomposition:
- Shared package fx2_pkg: FSM state enum, the EP_OUT/EP_IN defaults, header magic 4'hA, clog2 helper.
- Sub-module rr_arbiter (NCH-wide request vector, pointer in, one-hot grant out); reused elsewhere.

Test Plan:
- cy_flaga high for 5 cycles with FD stream 0x4C4F, 0x5044, 0x0001 -> dn_val pulses with dn_dat equal to those words in order, none lost or duplicated.
- up_req[0]=1, flagb=1, PKT_WORDS=256 -> exactly 256 slwr_n=0 cycles with cy_addr=2'b10 and data counting 0..255, then one up_fin[0] pulse.
- up_req=4'b1111 held -> packet grant order 0,1,2,3,0; each channel's up_fin fires once per packet.
- cy_flagb dropped for 10 cycles at word 100 -> slwr_n and grant both pause; the packet still totals 256 words with no duplicate.
- cy_flaga rises during WR -> the write packet completes first, then the read starts; cy_data is never driven while sloe_n=0.
- rst_n pulsed low at word 50 -> all strobes 1 in the same cycle; after release a new request restarts at word 0; with FX2_CHID_HDR_EN, the sequence restarts at 0.
